// File: rtl/regfile_writeback_pkg.sv
// Shared widths and the write-queue entry record for the register file
// write-back path; the read side imports the same package.
package regfile_writeback_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // One-hot register mask for a register index.
  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Generic synchronous FIFO with flush and parallel visibility of every
// slot plus a per-slot valid mask, so the owner can scan queued entries.
module wb_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0][W-1:0] slots,
  output logic [DEPTH-1:0]        slot_vld
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic                    do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign slots   = mem_q;

  // Next pointers, occupancy and storage; flush drops everything queued.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin : slot_valid
    logic [PW-1:0] off;
    off      = '0;
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PW'(i) - rd_ptr_q;
      slot_vld[i] = ({1'b0, off} < count_q);
    end
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage for the 8x16 register file: queues results, drains one
// per cycle onto the write port, and publishes pending-write hazards.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_vsel,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_sdata,
  input  logic [AW-1:0]     in_writenum,
  input  logic              wb_hold,
  input  logic              flush,
  output logic              write,
  output logic [AW-1:0]     writenum,
  output logic [DATA_W-1:0] data_in,
  output logic [NREG-1:0]   pending,
  output logic              status_z,
  output logic [7:0]        wb_count
);

  wb_entry_t                     in_entry, head;
  logic [ENTRY_W-1:0]            head_raw;
  logic [DEPTH-1:0][ENTRY_W-1:0] slots;
  logic [DEPTH-1:0]              slot_vld;
  logic                          full, empty, push, pop;

  logic              write_q, write_d;
  logic [AW-1:0]     writenum_q, writenum_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              status_z_q, status_z_d;
  logic [7:0]        wb_count_q, wb_count_d;

  // Source select happens at acceptance so the queue holds final data.
  always_comb begin
    in_entry.idx  = in_writenum;
    in_entry.data = in_vsel ? in_sdata : in_c;
  end

  // No pass-through when full: readiness depends only on occupancy.
  assign in_ready = ~full;
  assign push     = in_valid & ~full & ~flush;
  assign pop      = ~empty & ~wb_hold & ~flush;
  assign head     = wb_entry_t'(head_raw);

  wb_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wdata    (in_entry),
    .rdata    (head_raw),
    .full     (full),
    .empty    (empty),
    .slots    (slots),
    .slot_vld (slot_vld)
  );

  // Output stage loads the head on pop; commit bookkeeping follows a write.
  always_comb begin
    write_d    = pop;
    writenum_d = pop ? head.idx  : writenum_q;
    data_in_d  = pop ? head.data : data_in_q;
    wb_count_d = write_q ? wb_count_q + 8'd1 : wb_count_q;
    status_z_d = write_q ? (data_in_q == '0) : status_z_q;
  end

  // Hazard mask: every queued destination plus the one being written now.
  always_comb begin : pend_scan
    wb_entry_t e;
    e       = '0;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = wb_entry_t'(slots[i]);
      if (slot_vld[i]) pending = pending | reg_onehot(e.idx);
    end
    if (write_q) pending = pending | reg_onehot(writenum_q);
  end

  // Output stage, zero flag and commit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      writenum_q <= '0;
      data_in_q  <= '0;
      status_z_q <= 1'b0;
      wb_count_q <= '0;
    end else begin
      write_q    <= write_d;
      writenum_q <= writenum_d;
      data_in_q  <= data_in_d;
      status_z_q <= status_z_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign write    = write_q;
  assign writenum = writenum_q;
  assign data_in  = data_in_q;
  assign status_z = status_z_q;
  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: per-cycle vector table, queue-based
// scoreboard on every falling edge, and hand-written corner sequences.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_vsel, wb_hold, flush;
  logic [DATA_W-1:0] in_c, in_sdata, data_in;
  logic [AW-1:0]     in_writenum, writenum;
  logic              write, status_z;
  logic [NREG-1:0]   pending;
  logic [7:0]        wb_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vsel     (in_vsel),
    .in_c        (in_c),
    .in_sdata    (in_sdata),
    .in_writenum (in_writenum),
    .wb_hold     (wb_hold),
    .flush       (flush),
    .write       (write),
    .writenum    (writenum),
    .data_in     (data_in),
    .pending     (pending),
    .status_z    (status_z),
    .wb_count    (wb_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic vs, input logic [15:0] c,
                       input logic [15:0] sd, input logic [2:0] idx,
                       input logic h, input logic f);
    in_valid = v; in_vsel = vs; in_c = c; in_sdata = sd;
    in_writenum = idx; wb_hold = h; flush = f;
  endtask

  // ---------------- scoreboard ----------------
  wb_entry_t     exp_q[$];
  wb_entry_t     sb_e;
  logic          m_wr;
  logic [AW-1:0] m_wn;
  logic [15:0]   m_wd;
  logic [7:0]    m_cnt;
  logic          m_z;
  logic [7:0]    m_pend;
  logic          sb_pop, sb_acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_wr = 1'b0; m_wn = '0; m_wd = '0; m_cnt = '0; m_z = 1'b0;
    end else begin
      m_pend = '0;
      foreach (exp_q[k]) m_pend[exp_q[k].idx] = 1'b1;
      if (m_wr) m_pend[m_wn] = 1'b1;
      chk("sb_write", 32'(write), 32'(m_wr));
      if (m_wr) begin
        chk("sb_writenum", 32'(writenum), 32'(m_wn));
        chk("sb_data_in", 32'(data_in), 32'(m_wd));
      end
      chk("sb_pending", 32'(pending), 32'(m_pend));
      chk("sb_wb_count", 32'(wb_count), 32'(m_cnt));
      chk("sb_status_z", 32'(status_z), 32'(m_z));
      chk("sb_in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (m_wr) begin
        m_cnt = m_cnt + 8'd1;
        m_z   = (m_wd == 16'h0);
      end
      sb_pop = (exp_q.size() > 0) && !wb_hold && !flush;
      sb_acc = in_valid && (exp_q.size() < DEPTH) && !flush;
      if (flush) begin
        exp_q.delete();
        m_wr = 1'b0;
      end else begin
        m_wr = 1'b0;
        if (sb_pop) begin
          sb_e = exp_q.pop_front();
          m_wr = 1'b1; m_wn = sb_e.idx; m_wd = sb_e.data;
        end
        if (sb_acc) begin
          sb_e.idx  = in_writenum;
          sb_e.data = in_vsel ? in_sdata : in_c;
          exp_q.push_back(sb_e);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic v; logic vs; logic [15:0] c; logic [15:0] sd; logic [2:0] idx;
    logic h; logic f;
    logic rdy; logic wr; logic [2:0] wn; logic [15:0] wd; logic [7:0] pend;
    logic z; logic [7:0] cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    //            v     vs    c         sd        idx   h     f   | rdy   wr    wn    wd        pend    z     cnt
    tbl[0]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 8'h08, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 16'h1234, 8'h08, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h00, 1'b0, 8'd1};
    tbl[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 16'h1234, 8'h02, 1'b0, 8'd1};
    tbl[4]  = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 8'h06, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 16'hDEAD, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 8'h06, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 1'b0, 16'hBEEF, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h0005, 8'h06, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0000, 8'h04, 1'b0, 8'd2};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0000, 8'h00, 1'b1, 8'd3};
    tbl[9]  = '{1'b1, 1'b1, 16'h0000, 16'h0007, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0000, 8'h10, 1'b1, 8'd3};
    tbl[10] = '{1'b1, 1'b1, 16'h0000, 16'h0009, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0007, 8'h10, 1'b1, 8'd3};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0009, 8'h10, 1'b0, 8'd4};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h0009, 8'h00, 1'b0, 8'd5};
    tbl[13] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 16'h0009, 8'h20, 1'b0, 8'd5};
    tbl[14] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0009, 8'h60, 1'b0, 8'd5};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0011, 8'h60, 1'b0, 8'd5};
    tbl[16] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h0011, 8'h00, 1'b0, 8'd6};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0011, 8'h00, 1'b0, 8'd6};

    rst_n = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_writenum", 32'(writenum), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_status_z", 32'(status_z), 32'd0);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].vs, tbl[i].c, tbl[i].sd, tbl[i].idx, tbl[i].h, tbl[i].f);
      @(posedge clk);
      #2;
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_write", i), 32'(write), 32'(tbl[i].wr));
      chk($sformatf("row%0d_writenum", i), 32'(writenum), 32'(tbl[i].wn));
      chk($sformatf("row%0d_data_in", i), 32'(data_in), 32'(tbl[i].wd));
      chk($sformatf("row%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("row%0d_status_z", i), 32'(status_z), 32'(tbl[i].z));
      chk($sformatf("row%0d_wb_count", i), 32'(wb_count), 32'(tbl[i].cnt));
    end

    // Continuous stream of 250 results: no bubbles, counter wraps 6+250 -> 0.
    nwr = 0;
    for (int i = 0; i <= 250; i++) begin
      if (i < 250)
        drive(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              3'($urandom_range(0, 7)), 0, 0);
      else
        drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
      @(posedge clk);
      #2;
      if (write) nwr++;
    end
    chk("stream_write_cycles", 32'(nwr), 32'd250);
    chk("stream_wb_count_255", 32'(wb_count), 32'd255);
    @(posedge clk);
    #2;
    chk("stream_wb_count_wrap", 32'(wb_count), 32'd0);
    chk("stream_idle_write", 32'(write), 32'd0);

    // Reset mid-stream with work queued and a write in the output stage.
    drive(1, 0, 16'h00AA, 16'h0, 3'd1, 0, 0);
    @(posedge clk);
    #1 drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1 drive(1, 0, 16'h0BBB, 16'h0, 3'd2, 1, 0);
    @(posedge clk);
    #1 drive(1, 0, 16'h0CCC, 16'h0, 3'd3, 1, 0);
    @(posedge clk);
    #1 drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
    @(posedge clk);
    #2;
    chk("prerst_write", 32'(write), 32'd1);
    chk("prerst_pending", 32'(pending), 32'h0C);
    chk("prerst_wb_count", 32'(wb_count), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_write", 32'(write), 32'd0);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_wb_count", 32'(wb_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_write", 32'(write), 32'd0);
    drive(1, 1, 16'h0, 16'h5555, 3'd5, 0, 0);
    @(posedge clk);
    #1 drive(0, 0, 16'h0, 16'h0, 3'd0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("postrst_data_in", 32'(data_in), 32'h5555);
    chk("postrst_wb_count", 32'(wb_count), 32'd1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side companion to the 8x16 register file's read/loada/loadb path.
- Accepts results (ALU output C or external sdata, chosen by vsel) over a valid/ready handshake and buffers them in a small in-order queue.
- Drives the register file write port (write, writenum, data_in) one entry per cycle.
- Publishes a pending-write scoreboard so the read side can stall loada/loadb on a register with an outstanding write, plus a zero flag and a commit counter.

Parameters:
DATA_W, 16, register data width
NREG, 8, number of architectural registers
AW, 3, register index width (log2 NREG)
DEPTH, 2, write queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  result offered
in_ready  out  1  queue can accept (= !full)
in_vsel  in  1  1: write in_sdata, 0: write in_c
in_c  in  DATA_W  ALU result
in_sdata  in  DATA_W  external/immediate data
in_writenum  in  AW  destination register
wb_hold  in  1  freeze draining (register file busy)
flush  in  1  synchronous discard of all queued entries
write  out  1  register file write strobe
writenum  out  AW  register file write index
data_in  out  DATA_W  register file write data
pending  out  NREG  bit r = write to r outstanding
status_z  out  1  last committed data_in == 0
wb_count  out  8  committed-write counter

Behaviour:
- Reset (async, rst_n low): queue empty, write=0, writenum=0, data_in=0, status_z=0, wb_count=0, pending=0. in_ready=1 once the queue is empty.
- Push: on a rising edge with in_valid && in_ready && !flush, enqueue {in_writenum, in_vsel ? in_sdata : in_c}. The mux is evaluated at acceptance; later input changes are irrelevant.
- in_ready depends only on occupancy: no same-cycle pass-through when full, even if a pop occurs that edge.
- Pop: on a rising edge with queue non-empty && !wb_hold && !flush, dequeue the head into the output stage: write<=1, writenum<=entry.idx, data_in<=entry.data.
- On any edge without a pop: write<=0. writenum and data_in hold their values.
- Latency: accepted at edge k with empty queue and no hold -> popped at edge k+1 -> register file captures at edge k+2.
- Throughput: 1 write/cycle sustained. Simultaneous push and pop when not full are both performed; occupancy is unchanged.
- Commit (an edge where write==1): wb_count<=wb_count+1, wrapping 255->0; status_z<=(data_in==0).
- pending is combinational: OR of one-hot(idx) over valid queue entries, plus one-hot(writenum) while write==1. A bit clears the cycle after its last write commits.
- Duplicate destinations are kept in order; the last one wins in the register file, and pending stays set until it commits.
- flush: empties the queue and overrides push and pop that edge. An entry already in the output stage (write==1) still commits.
- wb_hold: blocks pop only; pushes continue until full.
- Queue pointers are AW-independent with log2(DEPTH) bits and wrap; occupancy uses a count of log2(DEPTH)+1 bits.

Decomposition:
- Shared package/header holds DATA_W, NREG, AW and the queue entry record {idx[AW-1:0], data[DATA_W-1:0]}, so the register file read side uses the same widths.
- One sub-module, wb_fifo: generic synchronous FIFO with push/pop/flush, full/empty and parallel visibility of valid entries (for pending).
- Top level adds the vsel mux, output stage, scoreboard, status_z and counter.

Test Plan:
- Reset mid-stream with 2 queued entries, rst_n low -> immediately write=0, pending=0, wb_count=0; in_ready=1 after release.
- Push {r3, vsel=0, c=16'h1234} into idle block -> write=1 with writenum=3, data_in=16'h1234 exactly one cycle after acceptance; pending[3] set for 2 cycles; wb_count=1, status_z=0.
- wb_hold=1, push r1=5 and r2=0 -> in_ready=0 after second push, pending=8'b0000_0110. Release hold -> writes r1 then r2 on consecutive cycles; status_z=1 after the r2 commit.
- Back-to-back pushes to r4 (vsel=1, sdata=7, then 9) -> two writes in order, data 7 then 9; pending[4] clears only after the second write.
- Queue holds 2 entries, assert flush while one entry sits in the output stage -> that write commits; queue empty; no further writes; pending reflects only the committing entry, then 0.
- 256 continuous commits -> wb_count wraps to 0; no bubbles while in_valid held high and no hold.
